// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle RV32 control unit and its datapath.
// The control unit is the master: it consumes the IR fields and the ALU
// zero flag, and drives every datapath select/enable plus debug status.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  // Decode inputs coming from the datapath
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic             zero;

  // Datapath control
  logic             PCWrite;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic             PCSource;
  logic [3:0]       ALUControl;

  // Status / debug
  logic [3:0]       state;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_retired;

  modport master (
    input  opcode, funct3, funct7_5, zero,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, PCSource, ALUControl,
           state, illegal_op, instr_retired
  );

  modport slave (
    output opcode, funct3, funct7_5, zero,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, PCSource, ALUControl,
           state, illegal_op, instr_retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control unit of the multicycle RV32 datapath.
// A Moore FSM walks FETCH -> DECODE -> execute -> writeback; all datapath
// selects are decoded from the state register (only the BRANCH PC enable
// looks at the live zero flag). After reset is released the FSM spends one
// "arming" cycle in FETCH with write enables gated, so no register, PC or
// memory write can happen before the first clean rising edge.
module multicycle_control #(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter int         CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    R_WB      = 4'd7,
    EXEC_I    = 4'd8,
    I_WB      = 4'd9,
    BRANCH    = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // True for the five opcodes this datapath can execute
  function automatic logic opcode_supported(input logic [6:0] op);
    case (op)
      OP_LW, OP_SW, OP_R, OP_ADDI, OP_BEQ: opcode_supported = 1'b1;
      default:                             opcode_supported = 1'b0;
    endcase
  endfunction

  // R-type ALU operation from {funct7[5], funct3}; funct7 only splits add/sub
  function automatic logic [3:0] r_alu_code(input logic f7_5, input logic [2:0] f3);
    case (f3)
      3'b000:  r_alu_code = f7_5 ? ALU_SUB : ALU_ADD;
      3'b111:  r_alu_code = ALU_AND;
      3'b110:  r_alu_code = ALU_OR;
      default: r_alu_code = ALU_ADD;
    endcase
  endfunction

  state_t           state_r;
  logic             armed_r;
  logic [CNT_W-1:0] retired_r;

  logic       pc_write_s;
  logic       iord_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       mem_to_reg_s;
  logic       reg_write_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic       pc_source_s;
  logic [3:0] alu_control_s;
  logic       illegal_op_s;

  // State sequencing, post-reset arming and retired-instruction counting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= state_t'(RESET_STATE);
      armed_r   <= 1'b0;
      retired_r <= '0;
    end else if (!armed_r) begin
      // first edge after release only arms the write enables
      armed_r <= 1'b1;
      state_r <= state_r;
    end else begin
      case (state_r)
        FETCH:  state_r <= DECODE;
        DECODE: begin
          case (bus.opcode)
            OP_LW, OP_SW: state_r <= MEM_ADDR;
            OP_R:         state_r <= EXEC_R;
            OP_ADDI:      state_r <= EXEC_I;
            OP_BEQ:       state_r <= BRANCH;
            default:      state_r <= FETCH;  // illegal: not retired
          endcase
        end
        MEM_ADDR: state_r <= (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
        // MDR latches every cycle, so writeback must follow the read directly
        MEM_READ: state_r <= MEM_WB;
        MEM_WB, MEM_WRITE, R_WB, I_WB, BRANCH: begin
          state_r   <= FETCH;
          retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        EXEC_R:   state_r <= R_WB;
        EXEC_I:   state_r <= I_WB;
        default:  state_r <= FETCH;
      endcase
    end
  end

  // Moore output decode; write enables are gated until the FSM is armed
  always_comb begin
    pc_write_s    = 1'b0;
    iord_s        = 1'b0;
    mem_read_s    = 1'b0;
    mem_write_s   = 1'b0;
    ir_write_s    = 1'b0;
    mem_to_reg_s  = 1'b0;
    reg_write_s   = 1'b0;
    alu_src_a_s   = 1'b0;
    alu_src_b_s   = 2'b00;
    pc_source_s   = 1'b0;
    alu_control_s = ALU_ADD;
    illegal_op_s  = 1'b0;
    case (state_r)
      FETCH: begin
        mem_read_s  = 1'b1;
        ir_write_s  = 1'b1;
        alu_src_b_s = 2'b01;
        pc_write_s  = 1'b1;
      end
      DECODE: begin
        alu_src_b_s  = 2'b10;
        illegal_op_s = !opcode_supported(bus.opcode);
      end
      MEM_ADDR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      MEM_READ: begin
        iord_s     = 1'b1;
        mem_read_s = 1'b1;
      end
      MEM_WB: begin
        mem_to_reg_s = 1'b1;
        reg_write_s  = 1'b1;
      end
      MEM_WRITE: begin
        iord_s      = 1'b1;
        mem_write_s = 1'b1;
      end
      EXEC_R: begin
        alu_src_a_s   = 1'b1;
        alu_control_s = r_alu_code(bus.funct7_5, bus.funct3);
      end
      R_WB, I_WB: begin
        reg_write_s = 1'b1;
      end
      EXEC_I: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      BRANCH: begin
        alu_src_a_s   = 1'b1;
        alu_control_s = ALU_SUB;
        pc_source_s   = 1'b1;
        pc_write_s    = bus.zero;
      end
      default: begin
        // unused encodings look like FETCH without any write
        mem_read_s  = 1'b1;
        alu_src_b_s = 2'b01;
      end
    endcase
    if (!armed_r) begin
      pc_write_s  = 1'b0;
      ir_write_s  = 1'b0;
      mem_write_s = 1'b0;
      reg_write_s = 1'b0;
    end else begin
      pc_write_s  = pc_write_s;
    end
  end

  assign bus.PCWrite       = pc_write_s;
  assign bus.IorD          = iord_s;
  assign bus.MemRead       = mem_read_s;
  assign bus.MemWrite      = mem_write_s;
  assign bus.IRWrite       = ir_write_s;
  assign bus.MemtoReg      = mem_to_reg_s;
  assign bus.RegWrite      = reg_write_s;
  assign bus.ALUSrcA       = alu_src_a_s;
  assign bus.ALUSrcB       = alu_src_b_s;
  assign bus.PCSource      = pc_source_s;
  assign bus.ALUControl    = alu_control_s;
  assign bus.state         = state_r;
  assign bus.illegal_op    = illegal_op_s;
  assign bus.instr_retired = retired_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control. Each table row is one
// clock cycle: inputs applied, then state / packed controls / retired count
// compared against hand-computed values. Reset corners are hand sequences.
module tb_multicycle_control;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110;

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        zero;
    logic [3:0]  exp_state;
    logic [15:0] exp_ctrl;
    logic [31:0] exp_cnt;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  multicycle_control_if #(.CNT_W(32)) bus ();
  multicycle_control_if #(.CNT_W(3))  bus3 ();

  multicycle_control #(.RESET_STATE(4'd0), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // narrow-counter copy, fed identically, to observe counter wrap
  multicycle_control #(.RESET_STATE(4'd0), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  assign bus3.opcode   = bus.opcode;
  assign bus3.funct3   = bus.funct3;
  assign bus3.funct7_5 = bus.funct7_5;
  assign bus3.zero     = bus.zero;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack expected controls: PCWrite IorD MemRead MemWrite IRWrite MemtoReg
  // RegWrite ALUSrcA ALUSrcB[1:0] PCSource ALUControl[3:0] illegal_op
  function automatic logic [15:0] mk(input logic pcw, input logic iord, input logic mr,
                                     input logic mw, input logic irw, input logic m2r,
                                     input logic rw, input logic asa, input logic [1:0] asb,
                                     input logic pcs, input logic [3:0] aluc, input logic ill);
    return {pcw, iord, mr, mw, irw, m2r, rw, asa, asb, pcs, aluc, ill};
  endfunction

  function automatic logic [15:0] c_fetch();  return mk(1,0,1,0,1,0,0,0,2'b01,0,A_ADD,0); endfunction
  function automatic logic [15:0] c_rst();    return mk(0,0,1,0,0,0,0,0,2'b01,0,A_ADD,0); endfunction
  function automatic logic [15:0] c_dec();    return mk(0,0,0,0,0,0,0,0,2'b10,0,A_ADD,0); endfunction
  function automatic logic [15:0] c_dec_ill(); return mk(0,0,0,0,0,0,0,0,2'b10,0,A_ADD,1); endfunction
  function automatic logic [15:0] c_maddr();  return mk(0,0,0,0,0,0,0,1,2'b10,0,A_ADD,0); endfunction
  function automatic logic [15:0] c_mread();  return mk(0,1,1,0,0,0,0,0,2'b00,0,A_ADD,0); endfunction
  function automatic logic [15:0] c_mwb();    return mk(0,0,0,0,0,1,1,0,2'b00,0,A_ADD,0); endfunction
  function automatic logic [15:0] c_mwrite(); return mk(0,1,0,1,0,0,0,0,2'b00,0,A_ADD,0); endfunction
  function automatic logic [15:0] c_wb();     return mk(0,0,0,0,0,0,1,0,2'b00,0,A_ADD,0); endfunction
  function automatic logic [15:0] c_exi();    return mk(0,0,0,0,0,0,0,1,2'b10,0,A_ADD,0); endfunction
  function automatic logic [15:0] c_exr(input logic [3:0] a); return mk(0,0,0,0,0,0,0,1,2'b00,0,a,0); endfunction
  function automatic logic [15:0] c_br(input logic z);        return mk(z,0,0,0,0,0,0,1,2'b00,1,A_SUB,0); endfunction

  function automatic vec_t row(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                               input logic z, input logic [3:0] st, input logic [15:0] ctrl,
                               input logic [31:0] cnt);
    vec_t v;
    v.opcode = op; v.funct3 = f3; v.funct7_5 = f7; v.zero = z;
    v.exp_state = st; v.exp_ctrl = ctrl; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] st, input logic [15:0] ctrl,
                       input logic [31:0] cnt);
    logic [15:0] act;
    act = {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg,
           bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.ALUControl, bus.illegal_op};
    n_checks++;
    if (bus.state !== st || act !== ctrl || bus.instr_retired !== cnt) begin
      n_fail++;
      $display("FAIL %s: got state=%0d ctrl=%b cnt=%0d, expected state=%0d ctrl=%b cnt=%0d",
               name, bus.state, act, bus.instr_retired, st, ctrl, cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watchdog: the run must never hang
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.funct7_5 = 1'b0; bus.zero = 1'b0;

    // lw: 5 cycles
    vecs.push_back(row(OP_LW, 3'b010, 0, 1, 4'd0, c_fetch(), 0));
    vecs.push_back(row(OP_LW, 3'b010, 0, 1, 4'd1, c_dec(),   0));
    vecs.push_back(row(OP_LW, 3'b010, 0, 1, 4'd2, c_maddr(), 0));
    vecs.push_back(row(OP_LW, 3'b010, 0, 1, 4'd3, c_mread(), 0));
    vecs.push_back(row(OP_LW, 3'b010, 0, 1, 4'd4, c_mwb(),   0));
    // sw: 4 cycles
    vecs.push_back(row(OP_SW, 3'b010, 0, 1, 4'd0, c_fetch(),  1));
    vecs.push_back(row(OP_SW, 3'b010, 0, 1, 4'd1, c_dec(),    1));
    vecs.push_back(row(OP_SW, 3'b010, 0, 1, 4'd2, c_maddr(),  1));
    vecs.push_back(row(OP_SW, 3'b010, 0, 1, 4'd5, c_mwrite(), 1));
    // R sub / and (funct7_5 ignored) / or / other funct3 -> add
    vecs.push_back(row(OP_R, 3'b000, 1, 0, 4'd0, c_fetch(),     2));
    vecs.push_back(row(OP_R, 3'b000, 1, 0, 4'd1, c_dec(),       2));
    vecs.push_back(row(OP_R, 3'b000, 1, 0, 4'd6, c_exr(A_SUB),  2));
    vecs.push_back(row(OP_R, 3'b000, 1, 0, 4'd7, c_wb(),        2));
    vecs.push_back(row(OP_R, 3'b111, 1, 1, 4'd0, c_fetch(),     3));
    vecs.push_back(row(OP_R, 3'b111, 1, 1, 4'd1, c_dec(),       3));
    vecs.push_back(row(OP_R, 3'b111, 1, 1, 4'd6, c_exr(A_AND),  3));
    vecs.push_back(row(OP_R, 3'b111, 1, 1, 4'd7, c_wb(),        3));
    vecs.push_back(row(OP_R, 3'b110, 0, 0, 4'd0, c_fetch(),     4));
    vecs.push_back(row(OP_R, 3'b110, 0, 0, 4'd1, c_dec(),       4));
    vecs.push_back(row(OP_R, 3'b110, 0, 0, 4'd6, c_exr(A_OR),   4));
    vecs.push_back(row(OP_R, 3'b110, 0, 0, 4'd7, c_wb(),        4));
    vecs.push_back(row(OP_R, 3'b100, 1, 0, 4'd0, c_fetch(),     5));
    vecs.push_back(row(OP_R, 3'b100, 1, 0, 4'd1, c_dec(),       5));
    vecs.push_back(row(OP_R, 3'b100, 1, 0, 4'd6, c_exr(A_ADD),  5));
    vecs.push_back(row(OP_R, 3'b100, 1, 0, 4'd7, c_wb(),        5));
    // addi: 4 cycles
    vecs.push_back(row(OP_ADDI, 3'b000, 1, 1, 4'd0, c_fetch(), 6));
    vecs.push_back(row(OP_ADDI, 3'b000, 1, 1, 4'd1, c_dec(),   6));
    vecs.push_back(row(OP_ADDI, 3'b000, 1, 1, 4'd8, c_exi(),   6));
    vecs.push_back(row(OP_ADDI, 3'b000, 1, 1, 4'd9, c_wb(),    6));
    // beq taken / not taken: 3 cycles each
    vecs.push_back(row(OP_BEQ, 3'b000, 0, 1, 4'd0,  c_fetch(), 7));
    vecs.push_back(row(OP_BEQ, 3'b000, 0, 1, 4'd1,  c_dec(),   7));
    vecs.push_back(row(OP_BEQ, 3'b000, 0, 1, 4'd10, c_br(1),   7));
    vecs.push_back(row(OP_BEQ, 3'b000, 0, 0, 4'd0,  c_fetch(), 8));
    vecs.push_back(row(OP_BEQ, 3'b000, 0, 0, 4'd1,  c_dec(),   8));
    vecs.push_back(row(OP_BEQ, 3'b000, 0, 0, 4'd10, c_br(0),   8));
    // illegal opcode: 2 cycles, not retired
    vecs.push_back(row(OP_BAD, 3'b000, 0, 0, 4'd0, c_fetch(),   9));
    vecs.push_back(row(OP_BAD, 3'b000, 0, 0, 4'd1, c_dec_ill(), 9));
    // fetch of an sw that will be interrupted by reset
    vecs.push_back(row(OP_SW, 3'b010, 0, 0, 4'd0, c_fetch(), 9));

    // reset held low for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", 4'd0, c_rst(), 0);
    end

    // release: enables stay off until the first rising edge
    reset = 1'b1;
    #1;
    check("release_pre_edge", 4'd0, c_rst(), 0);
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      bus.opcode   = vecs[i].opcode;
      bus.funct3   = vecs[i].funct3;
      bus.funct7_5 = vecs[i].funct7_5;
      bus.zero     = vecs[i].zero;
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_ctrl, vecs[i].exp_cnt);
      tick();
    end

    // 9 retired instructions in a 3-bit counter wraps to 1
    n_checks++;
    if (bus3.instr_retired !== 3'd1) begin
      n_fail++;
      $display("FAIL cnt_wrap: got %0d, expected 1", bus3.instr_retired);
    end

    // sw continues: DECODE, MEM_ADDR, MEM_WRITE
    check("sw2_decode", 4'd1, c_dec(), 9);
    tick();
    check("sw2_maddr", 4'd2, c_maddr(), 9);
    tick();
    check("sw2_mwrite", 4'd5, c_mwrite(), 9);

    // asynchronous reset in the middle of MEM_WRITE
    #2;
    reset = 1'b0;
    #1;
    check("mid_reset_async", 4'd0, c_rst(), 0);
    tick();
    check("mid_reset_hold", 4'd0, c_rst(), 0);
    reset = 1'b1;
    #1;
    check("mid_release_pre_edge", 4'd0, c_rst(), 0);
    tick();
    check("resume_fetch", 4'd0, c_fetch(), 0);
    tick();
    check("resume_decode", 4'd1, c_dec(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control unit for the multicycle RV32 datapath.
- Decodes the IR opcode/funct fields and the ALU zero flag.
- Sequences FETCH/DECODE/execute/writeback through a Moore FSM.
- Drives every mux select, write enable and the 4-bit ALU control code. It sits directly upstream of the datapath registers, muxes and ALU.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- zero  in  1  ALU zero flag
- PCWrite  out  1  PC load enable
- IorD  out  1  memory address select (1 = ALUOut)
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable
- IRWrite  out  1  IR load enable
- MemtoReg  out  1  register write-data select (1 = MDR)
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A select (1 = A register, 0 = PC)
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = immediate
- PCSource  out  1  1 = ALUOut, 0 = ALU result
- ALUControl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB
- state  out  4  current FSM state (debug)
- illegal_op  out  1  high in DECODE when opcode is unsupported
- instr_retired  out  CNT_W  count of completed instructions

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - While reset = 0: state = FETCH, instr_retired = 0.
  - While reset = 0: PCWrite, IRWrite, MemWrite and RegWrite are forced 0; all other outputs take their FETCH values.
- Moore outputs decoded from state only. The exception is PCWrite in BRANCH, which equals zero. Any signal not listed for a state is 0 (ALUSrcB 00, ALUControl 0010).
- Supported opcodes:
  - 0000011 lw
  - 0100011 sw
  - 0110011 R-type (add/sub/and/or)
  - 0010011 addi
  - 1100011 beq
- State encodings and outputs:
  - 0 FETCH: MemRead, IRWrite, IorD=0, ALUSrcA=0, ALUSrcB=01, ADD, PCSource=0, PCWrite. Next state: DECODE.
  - 1 DECODE: ALUSrcA=0, ALUSrcB=10, ADD; the branch target is latched into ALUOut.
    - Next state by opcode: lw/sw -> MEM_ADDR; R -> EXEC_R; addi -> EXEC_I; beq -> BRANCH.
    - Any other opcode -> FETCH with illegal_op=1.
  - 2 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ADD. Next state: lw -> MEM_READ, sw -> MEM_WRITE.
  - 3 MEM_READ: IorD=1, MemRead. Next state: MEM_WB.
  - 4 MEM_WB: MemtoReg=1, RegWrite. Next state: FETCH.
  - 5 MEM_WRITE: IorD=1, MemWrite. Next state: FETCH.
  - 6 EXEC_R: ALUSrcA=1, ALUSrcB=00, funct-decoded ALUControl. Next state: R_WB.
  - 7 R_WB: MemtoReg=0, RegWrite. Next state: FETCH.
  - 8 EXEC_I: ALUSrcA=1, ALUSrcB=10, ADD. Next state: I_WB.
  - 9 I_WB: MemtoReg=0, RegWrite. Next state: FETCH.
  - 10 BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=1, PCWrite=zero. Next state: FETCH.
  - 11-15: outputs as FETCH with write enables 0; next state is FETCH.
- R-type ALUControl (EXEC_R only), keyed on {funct7_5, funct3}:
  - {0,000} ADD
  - {1,000} SUB
  - {x,111} AND
  - {x,110} OR
  - others ADD
- Cycle counts: lw 5, sw 4, R 4, addi 4, beq 3, illegal 2.
- Field sampling: opcode/funct are sampled only in states >= DECODE; values during FETCH are ignored.
- MEM_WB must immediately follow MEM_READ because MDR latches unconditionally every cycle.
- instr_retired:
  - Increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, R_WB, I_WB or BRANCH.
  - Does not increment on the illegal DECODE -> FETCH path.
  - Wraps to 0 at 2^CNT_W.
- Reset asserted mid-instruction: state returns to FETCH immediately (asynchronous). No further write enable is issued until the first rising edge after reset deasserts.

Test Plan:
- Reset low for 3 cycles, then released -> state=0, instr_retired=0, PCWrite=IRWrite=MemWrite=RegWrite=0 while reset low. First cycle after release: MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01, ALUControl=0010.
- opcode=0000011 -> states 0,1,2,3,4,0. MEM_READ shows IorD=1, MemRead=1. MEM_WB shows MemtoReg=1, RegWrite=1. instr_retired 0 -> 1 on return to FETCH.
- opcode=0110011: funct7_5=1/funct3=000 -> EXEC_R ALUControl=0110. funct3=111 -> 0000. funct3=110 -> 0001. Each takes 4 cycles with RegWrite only in R_WB.
- opcode=1100011 with zero=1 -> BRANCH PCWrite=1, PCSource=1, ALUControl=0110. With zero=0 -> PCWrite=0. Both take 3 cycles and increment instr_retired.
- opcode=1111111 -> DECODE illegal_op=1, next state FETCH, instr_retired unchanged, no RegWrite/MemWrite asserted.
- Assert reset during MEM_WRITE -> MemWrite drops to 0 asynchronously, state=0. After release, normal FETCH resumes.
